acc_feeder: RTL and testbench
=============================

Name: acc_feeder

Overview:
Operand source and result collector for the accumulator core. On start_i it streams num_cnt_i operands from a synchronous-read operand buffer into the accumulator's run/valid/number inputs. It counts the returned valid pulses and reports the sum of that batch on result_o with a one-cycle done_o pulse. The accumulator core has no clear, so the feeder captures the accumulator value at start and reports the difference.

Parameters:
IN_DATA_WIDTH, 8, operand width; must match the accumulator core.
DWIDTH, 16, accumulator and result width.
AWIDTH, 6, operand buffer address width.
CWIDTH, 7, operand count width; legal counts are 0..2^CWIDTH-1.
TIMEOUT, 64, watchdog limit in cycles; used only with ACC_FEEDER_TIMEOUT_EN.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start a batch; sampled only in IDLE
base_addr_i  input  AWIDTH  first operand address; sampled with start_i
num_cnt_i  input  CWIDTH  number of operands; sampled with start_i
pause_i  input  1  stalls operand issue while high
mem_ce_o  output  1  buffer read enable
mem_addr_o  output  AWIDTH  buffer read address
mem_q_i  input  IN_DATA_WIDTH  buffer read data, valid 1 cycle after mem_ce_o
acc_run_o  output  1  accumulator run
acc_valid_o  output  1  accumulator operand valid
acc_number_o  output  IN_DATA_WIDTH  accumulator operand
acc_valid_i  input  1  accumulator result-valid pulse
acc_result_i  input  DWIDTH  accumulator running value
busy_o  output  1  batch in progress
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  DWIDTH  batch sum
error_o  output  1  watchdog fired; present only with ACC_FEEDER_TIMEOUT_EN

Behaviour:
- Clock and reset: clk is the clock. rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; all counters 0; base register 0.
- State IDLE:
  - start_i=1 latches base_addr_i, num_cnt_i and base <= acc_result_i.
  - If num_cnt_i != 0, go to ISSUE.
  - If num_cnt_i == 0, go to DONE with result_o = 0.
- State ISSUE:
  - Each cycle with pause_i=0: mem_ce_o=1, mem_addr_o = base_addr + issued, then issued++.
  - mem_addr_o wraps modulo 2^AWIDTH.
  - With pause_i=1: mem_ce_o=0 and issued holds.
  - When the last operand issues (issued reaches the count), go to DRAIN.
- State DRAIN: wait until received == count.
- State DONE:
  - done_o=1 for exactly one cycle; result_o is held.
  - Next state is IDLE.
- acc_valid_o is mem_ce_o registered by one cycle.
- acc_number_o = mem_q_i combinationally; it is don't-care when acc_valid_o=0.
- acc_run_o=1 in ISSUE and DRAIN; 0 otherwise.
- busy_o=1 in every state except IDLE. busy_o drops in the cycle after done_o.
- received increments on every acc_valid_i while in ISSUE or DRAIN. acc_valid_i in IDLE or DONE is ignored.
- Result capture:
  - On the edge that samples the final acc_valid_i, result_o <= acc_result_i - base (modulo 2^DWIDTH).
  - The state moves to DONE on that same edge.
  - So done_o rises 1 cycle after the final acc_valid_i.
- Latency, pause_i=0, N operands:
  - start_i at cycle 0; ce in cycles 1..N; acc_valid_o in cycles 2..N+1.
  - acc_valid_i in cycles 3..N+2; done_o in cycle N+3.
- result_o holds until the next batch's capture.
- start_i is ignored while busy_o=1. start_i asserted in the same cycle that DONE returns to IDLE is not accepted; the next start_i in IDLE is.
- Width: operands are zero-extended by the accumulator. A batch sum exceeding 2^DWIDTH-1 wraps; no overflow flag.
- Accumulator wrap between base capture and end of batch is handled correctly by the modular subtraction.
- Reset mid-batch: returns to IDLE immediately and no done_o is issued. rst_n is shared with the accumulator core.

Optional Feature:
ACC_FEEDER_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entering ISSUE and on every acc_valid_i, and counts every other cycle in ISSUE/DRAIN, including pause cycles.
  - When it reaches TIMEOUT, go to DONE with result_o = acc_result_i - base and error_o=1.
  - error_o is cleared on the next accepted start_i.
- Undefined: no counter, no error_o port, and DRAIN waits indefinitely.

Test Plan:
- Buffer[0..3]=1,2,3,4, acc at 0, start base_addr=0 cnt=4 -> ce cycles 1-4 addr 0..3, done_o at cycle 7, result_o=10.
- Acc pre-loaded to 100, buffer[10..12]=5,5,5, cnt=3 -> result_o=15 and acc_result_i=115 at done.
- base_addr=62 (AWIDTH=6), cnt=4 -> mem_addr_o sequence 62,63,0,1 and result is the sum of those four entries.
- cnt=4 with pause_i high during cycles 2-3 -> exactly 4 ce pulses, done_o at cycle 9, same result as unpaused; start_i pulsed mid-batch is ignored.
- cnt=0 -> done_o 1 cycle after start, result_o=0, no ce or acc_valid_o; rst_n low mid-batch -> all outputs 0, IDLE, no done_o.
- ACC_FEEDER_TIMEOUT_EN, TIMEOUT=8, acc_valid_i withheld after 2 of 4 responses -> done_o 9 cycles after the last acc_valid_i (8 counted cycles plus the DONE transition), error_o=1, and error_o cleared by the next start_i.

Source files
------------

// File: rtl/acc_feeder.sv
// Purpose: streams a batch of operands from a sync-read buffer into the accumulator core and reports the batch sum (acc value minus value captured at start).
// Latency: start -> first read 1 cycle; done_o pulses 1 cycle after the final acc_valid_i (N+3 cycles for N operands, no pause).
// Backpressure: pause_i stalls operand issue; start_i ignored while busy. Optional watchdog: define ACC_FEEDER_TIMEOUT_EN.
module acc_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 16,
    parameter int AWIDTH        = 6,
    parameter int CWIDTH        = 7,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    input  logic [CWIDTH-1:0]        num_cnt_i,
    input  logic                     pause_i,
    output logic                     mem_ce_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    input  logic                     acc_valid_i,
    input  logic [DWIDTH-1:0]        acc_result_i,
    output logic                     busy_o,
`ifdef ACC_FEEDER_TIMEOUT_EN
    output logic                     error_o,
`endif
    output logic                     done_o,
    output logic [DWIDTH-1:0]        result_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_base_addr;
    logic [CWIDTH-1:0]   r_cnt;
    logic [CWIDTH-1:0]   r_issued;
    logic [CWIDTH-1:0]   r_received;
    logic [DWIDTH-1:0]   r_base;
    logic [DWIDTH-1:0]   r_result;
    logic                r_acc_valid;
    logic                w_start;
    logic                w_ce;
    logic                w_active;
    logic                w_last_issue;
    logic                w_last_recv;
    logic                w_finish;
    logic                w_timeout;

    assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_last_issue = (r_issued + CWIDTH'(1)) == r_cnt;
    assign w_last_recv  = acc_valid_i && ((r_received + CWIDTH'(1)) == r_cnt);
    // Batch ends on the final response or, when enabled, on watchdog expiry.
    assign w_finish     = w_active && (w_last_recv || w_timeout);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and issue decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ce        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = (num_cnt_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_ce = !pause_i;
                if (w_ce && w_last_issue) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_DRAIN;
            S_DONE:  w_state_nxt = S_IDLE;
        endcase
        if (w_finish) w_state_nxt = S_DONE;
    end

    // Batch bookkeeping: latch request, count issues/responses, capture the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_addr <= '0;
            r_cnt       <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_base      <= '0;
            r_result    <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= w_ce;
            if (w_start) begin
                r_base_addr <= base_addr_i;
                r_cnt       <= num_cnt_i;
                r_base      <= acc_result_i;
                r_issued    <= '0;
                r_received  <= '0;
                if (num_cnt_i == '0) r_result <= '0;
            end
            if (w_ce) r_issued <= r_issued + CWIDTH'(1);
            if (w_active && acc_valid_i) r_received <= r_received + CWIDTH'(1);
            // Modular difference absorbs any accumulator wrap during the batch.
            if (w_finish) r_result <= acc_result_i - r_base;
        end
    end

`ifdef ACC_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd;
    logic           r_error;

    // Fires on the cycle that would bring the idle count to TIMEOUT.
    assign w_timeout = w_active && !acc_valid_i && (r_wd == WDW'(TIMEOUT - 1));

    // Watchdog: counts cycles since the last response while running; error sticks until next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_start) begin
                r_wd    <= '0;
                r_error <= 1'b0;
            end else if (w_active) begin
                r_wd <= acc_valid_i ? '0 : r_wd + WDW'(1);
            end
            if (w_timeout) r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    logic w_unused_timeout;
    // Keeps TIMEOUT referenced in builds without the watchdog.
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    assign mem_ce_o     = w_ce;
    assign mem_addr_o   = w_ce ? (r_base_addr + AWIDTH'(r_issued)) : '0;
    assign acc_run_o    = w_active;
    assign acc_valid_o  = r_acc_valid;
    assign acc_number_o = r_acc_valid ? mem_q_i : '0;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign result_o     = r_result;

endmodule

// File: tb/tb_acc_feeder.sv
// Bench for acc_feeder: buffer and accumulator models around the DUT, batches checked against
// sums, address sequences and cycle timing computed directly from the batch parameters.
// Optional watchdog scenario is exercised when ACC_FEEDER_TIMEOUT_EN is defined.
module tb_acc_feeder;
    logic        clk, rst_n, start_i, pause_i;
    logic [5:0]  base_addr_i, mem_addr_o;
    logic [6:0]  num_cnt_i;
    logic        mem_ce_o, acc_run_o, acc_valid_o, acc_valid_i, busy_o, done_o;
    logic [7:0]  mem_q_i, acc_number_o;
    logic [15:0] acc_result_i, result_o;
`ifdef ACC_FEEDER_TIMEOUT_EN
    logic        error_o;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [64];
    logic        acc_load = 1'b0;
    logic        acc_withhold = 1'b0;
    logic [15:0] acc_load_val = '0;

    int          obs_done_cyc, obs_first_ce, obs_ce, obs_av, obs_ndone;
    logic        obs_busy_after;
    logic [15:0] obs_result, obs_acc;
    logic [5:0]  obs_addr [$];

    acc_feeder #(.IN_DATA_WIDTH(8), .DWIDTH(16), .AWIDTH(6), .CWIDTH(7), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_cnt_i(num_cnt_i), .pause_i(pause_i), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
        .mem_q_i(mem_q_i), .acc_run_o(acc_run_o), .acc_valid_o(acc_valid_o),
        .acc_number_o(acc_number_o), .acc_valid_i(acc_valid_i), .acc_result_i(acc_result_i),
        .busy_o(busy_o),
`ifdef ACC_FEEDER_TIMEOUT_EN
        .error_o(error_o),
`endif
        .done_o(done_o), .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read operand buffer.
    always @(posedge clk) if (mem_ce_o) mem_q_i <= mem[mem_addr_o];

    // Accumulator core: no clear, one-cycle response, shares rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_result_i <= '0;
            acc_valid_i  <= 1'b0;
        end else if (acc_load) begin
            acc_result_i <= acc_load_val;
            acc_valid_i  <= 1'b0;
        end else begin
            acc_valid_i <= acc_run_o && acc_valid_o && !acc_withhold;
            if (acc_run_o && acc_valid_o && !acc_withhold)
                acc_result_i <= acc_result_i + {8'h00, acc_number_o};
        end
    end

    function automatic logic [15:0] model_sum(input logic [5:0] b, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(mem[(int'(b) + i) % 64]);
        return s[15:0];
    endfunction

    // Cycle of done_o relative to the start cycle: last issue cycle + 3.
    function automatic int model_done(input int n, input logic [63:0] pm);
        int issued = 0;
        int last = 0;
        int k = 1;
        if (n == 0) return 1;
        while (issued < n) begin
            if (!(k < 64 && pm[k[5:0]])) begin
                issued++;
                last = k;
            end
            k++;
        end
        return last + 3;
    endfunction

    task automatic preload(input logic [15:0] v);
        @(posedge clk); #1;
        acc_load = 1'b1;
        acc_load_val = v;
        @(posedge clk); #1;
        acc_load = 1'b0;
    endtask

    // Drives one batch (start in cycle 0) and records what the DUT did.
    task automatic run_batch(input logic [5:0] b, input logic [6:0] n, input logic [63:0] pm,
                             input int mid_k, input int budget);
        obs_addr.delete();
        obs_done_cyc = -1; obs_first_ce = -1; obs_ce = 0; obs_av = 0; obs_ndone = 0;
        obs_busy_after = 1'bx; obs_result = 'x; obs_acc = 'x;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            start_i     = (k == 0) || (k == mid_k);
            base_addr_i = (k == 0) ? b : 6'($urandom);
            num_cnt_i   = (k == 0) ? n : 7'($urandom);
            pause_i     = (k < 64) ? pm[k[5:0]] : 1'b0;
            @(negedge clk);
            if (mem_ce_o) begin
                obs_addr.push_back(mem_addr_o);
                obs_ce++;
                if (obs_first_ce < 0) obs_first_ce = k;
            end
            if (acc_valid_o) obs_av++;
            if (done_o) begin
                obs_ndone++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = k;
                    obs_result = result_o;
                    obs_acc = acc_result_i;
                end
            end
            if (obs_done_cyc >= 0 && k == obs_done_cyc + 1) begin
                obs_busy_after = busy_o;
                break;
            end
        end
        start_i = 1'b0;
        pause_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; pause_i = 1'b0; base_addr_i = '0; num_cnt_i = '0;
        #1;
        checks++;
        if ({mem_ce_o, acc_run_o, acc_valid_o, busy_o, done_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {mem_ce_o, acc_run_o, acc_valid_o, busy_o, done_o});
        end
        checks++;
        if (result_o !== 16'h0 || mem_addr_o !== 6'h0 || acc_number_o !== 8'h0) begin
            failures++;
            $display("FAIL reset_data result=%0h addr=%0h num=%0h exp=0", result_o, mem_addr_o, acc_number_o);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        run_batch(6'd0, 7'd4, 64'h0, 7, 40);   // start in the DONE cycle must be ignored
        checks++;
        if (obs_first_ce != 1 || obs_ce != 4) begin
            failures++;
            $display("FAIL basic_ce first=%0d count=%0d exp first=1 count=4", obs_first_ce, obs_ce);
        end
        checks++;
        if (obs_addr.size() != 4 || obs_addr[0] != 0 || obs_addr[1] != 1 || obs_addr[2] != 2 || obs_addr[3] != 3) begin
            failures++;
            $display("FAIL basic_addr size=%0d exp seq 0,1,2,3", obs_addr.size());
        end
        checks++;
        if (obs_done_cyc != 7 || obs_result !== 16'd10) begin
            failures++;
            $display("FAIL basic_done cyc=%0d result=%0d exp cyc=7 result=10", obs_done_cyc, obs_result);
        end
        checks++;
        if (obs_busy_after !== 1'b0 || obs_ndone != 1) begin
            failures++;
            $display("FAIL basic_busy_drop busy=%b ndone=%0d exp busy=0 ndone=1", obs_busy_after, obs_ndone);
        end
    endtask

    task automatic test_preload();
        mem[10] = 8'd5; mem[11] = 8'd5; mem[12] = 8'd5;
        preload(16'd100);
        run_batch(6'd10, 7'd3, 64'h0, -1, 40);
        checks++;
        if (obs_result !== 16'd15 || obs_acc !== 16'd115 || obs_done_cyc != 6) begin
            failures++;
            $display("FAIL preload result=%0d acc=%0d cyc=%0d exp 15 115 6", obs_result, obs_acc, obs_done_cyc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        mem[62] = 8'($urandom); mem[63] = 8'($urandom); mem[0] = 8'($urandom); mem[1] = 8'($urandom);
        exp = model_sum(6'd62, 4);
        run_batch(6'd62, 7'd4, 64'h0, -1, 40);
        checks++;
        if (obs_addr.size() != 4 || obs_addr[0] != 62 || obs_addr[1] != 63 || obs_addr[2] != 0 || obs_addr[3] != 1) begin
            failures++;
            $display("FAIL wrap_addr size=%0d exp seq 62,63,0,1", obs_addr.size());
        end
        checks++;
        if (obs_result !== exp) begin
            failures++;
            $display("FAIL wrap_result got=%0d exp=%0d", obs_result, exp);
        end
    endtask

    task automatic test_zero_cnt();
        run_batch(6'($urandom), 7'd0, 64'h0, -1, 20);
        checks++;
        if (obs_done_cyc != 1 || obs_result !== 16'd0) begin
            failures++;
            $display("FAIL zero_done cyc=%0d result=%0d exp cyc=1 result=0", obs_done_cyc, obs_result);
        end
        checks++;
        if (obs_ce != 0 || obs_av != 0 || obs_busy_after !== 1'b0) begin
            failures++;
            $display("FAIL zero_quiet ce=%0d av=%0d busy=%b exp 0 0 0", obs_ce, obs_av, obs_busy_after);
        end
    endtask

    task automatic test_pause();
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) mem[20 + i] = 8'($urandom_range(1, 255));
        exp = model_sum(6'd20, 4);
        run_batch(6'd20, 7'd4, 64'h000000000000000C, 5, 40);
        checks++;
        if (obs_ce != 4 || obs_av != 4) begin
            failures++;
            $display("FAIL pause_pulses ce=%0d av=%0d exp 4 4", obs_ce, obs_av);
        end
        checks++;
        if (obs_done_cyc != 9 || obs_result !== exp || obs_ndone != 1) begin
            failures++;
            $display("FAIL pause_done cyc=%0d result=%0d nd=%0d exp 9 %0d 1", obs_done_cyc, obs_result, obs_ndone, exp);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 6'd0; num_cnt_i = 7'd20;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_ce_o, acc_run_o, acc_valid_o, busy_o, done_o} !== 5'b0 || result_o !== 16'h0 || acc_number_o !== 8'h0) begin
            failures++;
            $display("FAIL reset_mid ctrl=%b result=%0h num=%0h exp all 0",
                     {mem_ce_o, acc_run_o, acc_valid_o, busy_o, done_o}, result_o, acc_number_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_o || busy_o || mem_ce_o) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_mid_after stray_cycles=%0d exp=0", stray);
        end
    endtask

    task automatic test_random();
        logic [63:0] pm;
        logic [15:0] pre, exp_sum, exp_acc;
        logic [5:0]  b;
        int          n, exp_done, bad;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            for (int j = 0; j < 64; j++) pm[j] = ($urandom_range(0, 7) == 0);
            pre = 16'($urandom);
            b = 6'($urandom);
            n = (it == 0) ? 127 : $urandom_range(1, 127);
            exp_sum = model_sum(b, n);
            exp_acc = pre + exp_sum;
            exp_done = model_done(n, pm);
            preload(pre);
            run_batch(b, 7'(n), pm, -1, n + 90);
            checks++;
            if (obs_result !== exp_sum || obs_acc !== exp_acc) begin
                failures++;
                $display("FAIL rnd_result it=%0d got=%0h acc=%0h exp=%0h acc=%0h", it, obs_result, obs_acc, exp_sum, exp_acc);
            end
            checks++;
            if (obs_done_cyc != exp_done || obs_ndone != 1 || obs_busy_after !== 1'b0) begin
                failures++;
                $display("FAIL rnd_timing it=%0d cyc=%0d nd=%0d busy=%b exp cyc=%0d", it, obs_done_cyc, obs_ndone, obs_busy_after, exp_done);
            end
            bad = (obs_addr.size() != n || obs_av != n) ? 1 : 0;
            for (int i = 0; i < obs_addr.size() && i < n; i++)
                if (obs_addr[i] != 6'((int'(b) + i) % 64)) bad = 1;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rnd_addr it=%0d issued=%0d av=%0d exp=%0d base=%0d", it, obs_addr.size(), obs_av, n, b);
            end
        end
    endtask

`ifdef ACC_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int last_v, done_k, nv;
        logic [15:0] exp;
        logic        err_at_done;
        for (int i = 0; i < 4; i++) mem[30 + i] = 8'($urandom);
        exp = 16'(mem[30]) + 16'(mem[31]);
        last_v = -1; done_k = -1; nv = 0; err_at_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            start_i = (k == 0); base_addr_i = 6'd30; num_cnt_i = 7'd4;
            @(negedge clk);
            if (acc_valid_i) begin
                nv++;
                last_v = k;
                if (nv == 2) acc_withhold = 1'b1;
            end
            if (done_o) begin
                done_k = k;
                obs_result = result_o;
                err_at_done = error_o;
                break;
            end
        end
        start_i = 1'b0;
        acc_withhold = 1'b0;
        checks++;
        if (last_v != 4 || done_k != last_v + 9) begin
            failures++;
            $display("FAIL timeout_cycle last_valid=%0d done=%0d exp 4 13", last_v, done_k);
        end
        checks++;
        if (obs_result !== exp || err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_result got=%0d err=%b exp=%0d err=1", obs_result, err_at_done, exp);
        end
        run_batch(6'd0, 7'd0, 64'h0, -1, 20);
        checks++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear error=%b exp=0", error_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_preload();
        test_wrap();
        test_zero_cnt();
        test_pause();
        test_reset_mid();
        test_random();
`ifdef ACC_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
